// File: rtl/alu_lite_pkg.sv
// alu_lite_pkg: op codes, chunk field constants and chunk encoder shared by issuer, decoder and models
package alu_lite_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SLL  = 3'd2,
    OP_SRL  = 3'd3,
    OP_MULL = 3'd4,
    OP_MULH = 3'd5,
    OP_DIV  = 3'd6,
    OP_ILL  = 3'd7
  } alu_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam logic [6:0] GRP_ARITH  = 7'b0000001;
  localparam logic [6:0] GRP_SHIFT  = 7'b0000010;
  localparam logic [6:0] GRP_MULDIV = 7'b0001000;
  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SUB  = 3'b010;
  localparam logic [2:0] F_SLL  = 3'b000;
  localparam logic [2:0] F_SRL  = 3'b010;
  localparam logic [2:0] F_MULL = 3'b000;
  localparam logic [2:0] F_MULH = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  // group in [31:25], funct in [14:12], every other bit zero
  function automatic logic [31:0] encode_chunk(alu_op_t op);
    logic [6:0] grp;
    logic [2:0] fn;
    grp = (op == OP_ADD || op == OP_SUB) ? GRP_ARITH :
          (op == OP_SLL || op == OP_SRL) ? GRP_SHIFT :
          (op == OP_ILL) ? 7'd0 : GRP_MULDIV;
    fn  = (op == OP_SUB)  ? F_SUB  :
          (op == OP_SRL)  ? F_SRL  :
          (op == OP_MULH) ? F_MULH :
          (op == OP_DIV)  ? F_DIV  : 3'b000;
    return {grp, 10'd0, fn, 12'd0};
  endfunction
endpackage

// File: rtl/alu_lite_issuer.sv
// alu_lite_issuer: turns valid/ready op requests into alu_lite chunks and returns the result
//   clk, reset_n          : clock, async active-low reset
//   req_valid/ready/op/arg1/arg2 : request channel
//   rsp_valid/ready/data/err     : response channel (err on illegal op or divide by zero)
//   alu_chunk/arg1/arg2, alu_res : connection to one alu_lite instance
module alu_lite_issuer
  import alu_lite_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RES_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_arg1,
  input  logic [DATA_WIDTH-1:0] req_arg2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [31:0]           alu_chunk,
  output logic [DATA_WIDTH-1:0] alu_arg1,
  output logic [DATA_WIDTH-1:0] alu_arg2,
  input  logic [DATA_WIDTH-1:0] alu_res
);
  state_t     state;
  logic [3:0] cnt;
  logic       reject;
  alu_op_t    op;
  assign op        = alu_op_t'(req_op);
  assign reject    = (op == OP_ILL) || (op == OP_DIV && req_arg2 == '0);
  assign req_ready = (state == ST_IDLE);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_chunk <= '0;
      alu_arg1  <= '0;
      alu_arg2  <= '0;
    end else
      case (state)
        ST_IDLE:
          if (req_valid) begin
            if (reject) begin
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_chunk <= encode_chunk(op);
              alu_arg1  <= req_arg1;
              alu_arg2  <= req_arg2;
              cnt       <= 4'(RES_LATENCY);
              state     <= ST_WAIT;
            end
          end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          // counter reads 1 on the edge RES_LATENCY after issue
          if (cnt == 4'd1) begin
            rsp_data  <= alu_res;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        default:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
      endcase
endmodule

// File: doc/alu_lite_issuer.md
Name: alu_lite_issuer

Overview:
Initiator side of the alu_lite port: accepts operation requests over a valid/ready interface and encodes each into the alu_lite instruction chunk. Drives chunk/arg1/arg2, waits the ALU result latency, captures res and returns it over a valid/ready response interface. Sits between a command source (sequencer or bench driver) and one alu_lite instance. It is the producer of chunks that alu_lite decodes.

Parameters:
DATA_WIDTH, 32, width of arguments and result.
RES_LATENCY, 1, clock edges from chunk/args update to the edge where alu_res is sampled (1 for N_CYCLE=0); legal range 1..15.

Ports:
clk  input  1  clock, all state on posedge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  issuer can accept request.
req_op  input  3  op code: 0 ADD, 1 SUB, 2 SHIFT_LEFT, 3 SHIFT_RIGHT, 4 MUL_LOW, 5 MUL_HIGH, 6 DIV, 7 illegal.
req_arg1  input  DATA_WIDTH  first operand.
req_arg2  input  DATA_WIDTH  second operand.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  DATA_WIDTH  captured ALU result (0 on error).
rsp_err  output  1  request rejected (illegal op or DIV by zero).
alu_chunk  output  32  instruction chunk to alu_lite.
alu_arg1  output  DATA_WIDTH  operand 1 to alu_lite.
alu_arg2  output  DATA_WIDTH  operand 2 to alu_lite.
alu_res  input  DATA_WIDTH  result from alu_lite.

Behaviour:
- Reset (async, any state): state IDLE, req_ready=1 after deassert, rsp_valid=0, rsp_data=0, rsp_err=0, alu_chunk=0, alu_arg1=0, alu_arg2=0, latency counter=0. In-flight op discarded, no response.
- Chunk encoding: bits [31:25]=group, [14:12]=funct, all other bits driven 0 (never x).
  ADD 0000001/000, SUB 0000001/010, SHIFT_LEFT 0000010/000, SHIFT_RIGHT 0000010/010, MUL_LOW 0001000/000, MUL_HIGH 0001000/001, DIV 0001000/010.
- FSM states IDLE, WAIT, RESP. Outputs registered. req_ready = (state==IDLE), no combinational path from rsp_ready.
- IDLE: accept edge E = posedge with req_valid&&req_ready.
  - Legal op (and not DIV with arg2==0): at E load alu_chunk/alu_arg1/alu_arg2 and counter=RES_LATENCY, go WAIT.
  - Illegal op (7) or DIV with req_arg2==0: alu_* unchanged, at E set rsp_err=1, rsp_data=0, rsp_valid=1, go RESP. Nothing is issued to the ALU.
- WAIT: counter decrements each edge. At edge E+RES_LATENCY capture alu_res into rsp_data, rsp_err=0, rsp_valid=1, go RESP. req inputs ignored.
- RESP: rsp_valid, rsp_data and rsp_err are held stable until the rsp_valid&&rsp_ready edge. On that edge rsp_valid=0 and the FSM goes to IDLE.
- alu_chunk/alu_arg* hold the last issued values until the next legal issue.
- Throughput: one op per RES_LATENCY+2 cycles minimum (rsp_ready held high).
- Operand width rules: none applied here. Shift amounts >= DATA_WIDTH and MUL_HIGH semantics are passed through; alu_lite defines the result.
- req_* changes while req_ready=0 have no effect. rsp_ready while rsp_valid=0 is ignored.

Decomposition:
- Package alu_lite_pkg:
  - op enum alu_op_t (values above).
  - group constants GRP_ARITH=7'b0000001, GRP_SHIFT=7'b0000010, GRP_MULDIV=7'b0001000.
  - funct constants.
  - Automatic function encode_chunk(alu_op_t) returning 32 bits.
  - The same package serves alu_lite decode and bench reference models.
- No sub-module. Encoding is the package function; FSM and datapath are in alu_lite_issuer.

Test Plan:
- Bench pairing: issuer connected to alu_lite (N_CYCLE=0, RES_LATENCY=1).
- ADD 120,12 -> alu_chunk=32'h0200_0000 at E, rsp_valid at E+1 edge, rsp_data=132, rsp_err=0.
- SUB 120,12 then MUL_HIGH 32'hFFFF_FFFF,2, rsp_ready=1 -> chunks 32'h0200_2000 and 32'h1000_1000; rsp_data=108 then 1; req_ready low for exactly RES_LATENCY+1 cycles per op.
- DIV 100,0 and op 7 -> rsp_err=1, rsp_data=0 one edge after acceptance; alu_chunk/args unchanged from prior op.
- Backpressure: SHIFT_LEFT 1,4 with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_data=16 stable all 5 cycles; req_ready=0 until the response handshake edge.
- Reset mid-WAIT (RES_LATENCY=4, assert reset_n=0 two cycles after issue of ADD 1,1) -> all outputs 0 immediately, no response after release, next ADD 2,3 returns 5.
- Random legal ops (10 per op) checked against a package-based reference model, rsp_ready toggled randomly -> zero mismatches, every accepted request yields exactly one response.
